// File: rtl/mem_pkg.sv
// mem_pkg: shared op codes, FSM states (LD_HI/ST_HI only with MEM_MISALIGN_SPLIT_EN) and width-mask helper for mem_access
package mem_pkg;
  typedef enum logic [2:0] {MS_LB, MS_LH, MS_LW, MS_LBU, MS_LHU, MS_SB, MS_SH, MS_SW} mem_spec_e;
  localparam logic [4:0] SPEC_LB = 5'(MS_LB);
  localparam logic [4:0] SPEC_LH = 5'(MS_LH);
  localparam logic [4:0] SPEC_LW = 5'(MS_LW);
  localparam logic [4:0] SPEC_LBU = 5'(MS_LBU);
  localparam logic [4:0] SPEC_LHU = 5'(MS_LHU);
  localparam logic [4:0] SPEC_SB = 5'(MS_SB);
  localparam logic [4:0] SPEC_SH = 5'(MS_SH);
  localparam logic [4:0] SPEC_SW = 5'(MS_SW);
`ifdef MEM_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, LD_RESP, LD_HI, ST_HI} mem_state_e;
`else
  typedef enum logic [1:0] {IDLE, LD_RESP} mem_state_e;
`endif
  function automatic logic [3:0] width_mask(input logic [4:0] spec);
    return (spec == SPEC_LW || spec == SPEC_SW) ? 4'hf :
           (spec == SPEC_LH || spec == SPEC_LHU || spec == SPEC_SH) ? 4'h3 : 4'h1;
  endfunction
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: single-port 32-bit data SRAM, sync 1-cycle read, byte enables; ports clk addr we[3:0] wdat -> rdata
module dmem_sram #(parameter int DEPTH_WORDS = 1024) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdat,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we[i]) mem[addr][8*i +: 8] <= wdat[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory-stage load/store responder; in clk rst_n mem_read_en mem_write_en mem_addr mem_dat mem_spec rd_ind, out stall wb_valid wb_rd_ind wb_dat misalign_fault; MEM_MISALIGN_SPLIT_EN splits misaligned accesses
module mem_access
  import mem_pkg::*;
#(parameter int DEPTH_WORDS = 1024) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dat,
  input  logic [4:0]  mem_spec,
  input  logic [4:0]  rd_ind,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_ind,
  output logic [31:0] wb_dat,
  output logic        misalign_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  mem_state_e state, state_n;
  logic [AW-1:0] w, addr;
  logic [1:0] off;
  logic [7:0] be8;
  logic [3:0] we;
  logic [31:0] rdata, lane, ext, wdat;
  logic [63:0] src;
  logic idle, illegal, go, mis, fault_n, unused_addr;
  assign unused_addr = ^mem_addr[31:AW+2];
  assign w = mem_addr[AW+1:2];
  assign off = mem_addr[1:0];
  assign be8 = {4'b0, width_mask(mem_spec)} << off;
  assign mis = |be8[7:4];
  assign idle = state == IDLE;
  assign stall = !idle;
  assign illegal = (mem_read_en & mem_write_en) | ((mem_read_en | mem_write_en) & (mem_spec > 5'd7));
  assign go = idle & (mem_read_en ^ mem_write_en) & ~illegal;
`ifdef MEM_MISALIGN_SPLIT_EN
  logic [31:0] lo_q;
  logic [63:0] dat64;
  assign dat64 = {32'b0, mem_dat} << {off, 3'b0};
  assign fault_n = idle & illegal;
  assign we = !rst_n ? 4'b0 : (go & mem_write_en) ? be8[3:0] : (state == ST_HI) ? be8[7:4] : 4'b0;
  assign wdat = state == ST_HI ? dat64[63:32] : dat64[31:0];
  assign addr = idle ? w : w + AW'(1);
  assign src = mis ? {rdata, lo_q} : {32'b0, rdata};
  assign state_n = idle ? ((go & mem_read_en) ? (mis ? LD_HI : LD_RESP) : (go & mis) ? ST_HI : IDLE) :
                   state == LD_HI ? LD_RESP : IDLE;
  always_ff @(posedge clk) if (state == LD_HI) lo_q <= rdata;
`else
  assign fault_n = idle & (illegal | (go & mis));
  assign we = (rst_n & go & mem_write_en & ~mis) ? be8[3:0] : 4'b0;
  assign wdat = mem_dat << {off, 3'b0};
  assign addr = w;
  assign src = {32'b0, rdata};
  assign state_n = (go & mem_read_en & ~mis) ? LD_RESP : IDLE;
`endif
  assign lane = 32'(src >> {off, 3'b0});
  assign ext = mem_spec == SPEC_LB  ? {{24{lane[7]}}, lane[7:0]} :
               mem_spec == SPEC_LH  ? {{16{lane[15]}}, lane[15:0]} :
               mem_spec == SPEC_LBU ? {24'b0, lane[7:0]} :
               mem_spec == SPEC_LHU ? {16'b0, lane[15:0]} : lane;
  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (.clk(clk), .addr(addr), .we(we), .wdat(wdat), .rdata(rdata));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wb_valid <= 1'b0;
      wb_rd_ind <= 5'b0;
      wb_dat <= 32'b0;
      misalign_fault <= 1'b0;
    end else begin
      state <= state_n;
      wb_valid <= state == LD_RESP;
      misalign_fault <= fault_n;
      if (state == LD_RESP) begin
        wb_rd_ind <= rd_ind;
        wb_dat <= ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access
module tb_mem_access;
`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic clk, rst_n, mem_read_en, mem_write_en, stall, wb_valid, misalign_fault;
  logic [31:0] mem_addr, mem_dat, wb_dat;
  logic [4:0] mem_spec, rd_ind, wb_rd_ind;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [4:0] rd; logic [31:0] dat; int cyc;} wb_t;
  wb_t wbq[$];
  int fq[$];
  wb_t e;
  int fc;

  mem_access #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_dat(mem_dat), .mem_spec(mem_spec), .rd_ind(rd_ind),
    .stall(stall), .wb_valid(wb_valid), .wb_rd_ind(wb_rd_ind), .wb_dat(wb_dat),
    .misalign_fault(misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (wb_valid) begin
      if (wbq.size() == 0) check("wb_unexpected", {27'b0, wb_rd_ind}, 32'hffffffff);
      else begin
        e = wbq.pop_front();
        check("wb_rd_ind", {27'b0, wb_rd_ind}, {27'b0, e.rd});
        check("wb_dat", wb_dat, e.dat);
        check("wb_cycle", cyc, e.cyc);
      end
    end
    if (misalign_fault) begin
      if (fq.size() == 0) check("fault_unexpected", 32'd1, 32'd0);
      else begin
        fc = fq.pop_front();
        check("fault_cycle", cyc, fc);
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [4:0] sp, input logic [4:0] ri, input int es, input int lat,
                     input logic [31:0] ed, input bit flt);
    int st = 0;
    mem_read_en = rd; mem_write_en = wr; mem_addr = a; mem_dat = d; mem_spec = sp; rd_ind = ri;
    @(posedge clk); #1;
    if (lat > 0) wbq.push_back('{ri, ed, cyc + lat});
    if (flt) fq.push_back(cyc);
    while (stall && st < 8) begin st++; @(posedge clk); #1; end
    check("stall_cycles", st, es);
    mem_read_en = 1'b0; mem_write_en = 1'b0;
  endtask

  task automatic st_(input logic [31:0] a, input logic [31:0] d, input logic [4:0] sp);
    req(1'b0, 1'b1, a, d, sp, 5'd0, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [4:0] sp, input logic [4:0] ri, input logic [31:0] ed);
    req(1'b1, 1'b0, a, 32'h0, sp, ri, 1, 1, ed, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    mem_addr = 32'h0; mem_dat = 32'h0; mem_spec = 5'd0; rd_ind = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_rd_ind", {27'b0, wb_rd_ind}, 32'd0);
    check("rst_wb_dat", wb_dat, 32'd0);
    check("rst_fault", {31'b0, misalign_fault}, 32'd0);
    rst_n = 1'b1;
    st_(32'h10, 32'hdeadbeef, 5'd7);
    ld(32'h13, 5'd0, 5'd1, 32'hffffffde);
    ld(32'h13, 5'd3, 5'd2, 32'h000000de);
    ld(32'h11, 5'd1, 5'd3, 32'hffffadbe);
    ld(32'h12, 5'd4, 5'd4, 32'h0000dead);
    ld(32'h10, 5'd2, 5'd5, 32'hdeadbeef);
    st_(32'h20, 32'h12345678, 5'd7);
    st_(32'h22, 32'h00008001, 5'd6);
    ld(32'h22, 5'd1, 5'd6, 32'hffff8001);
    ld(32'h22, 5'd4, 5'd7, 32'h00008001);
    ld(32'h20, 5'd4, 5'd8, 32'h00005678);
    ld(32'h20, 5'd2, 5'd9, 32'h80015678);
    st_(32'h11, 32'h000001ff, 5'd5);
    ld(32'h10, 5'd2, 5'd10, 32'hdeadffef);
    req(1'b1, 1'b1, 32'h10, 32'h0, 5'd7, 5'd11, 0, 0, 32'h0, 1'b1);
    req(1'b0, 1'b1, 32'h10, 32'h0, 5'd9, 5'd11, 0, 0, 32'h0, 1'b1);
    req(1'b1, 1'b0, 32'h10, 32'h0, 5'd8, 5'd11, 0, 0, 32'h0, 1'b1);
    ld(32'h10, 5'd2, 5'd12, 32'hdeadffef);
    st_(32'h1000, 32'hcafef00d, 5'd7);
    ld(32'h0, 5'd2, 5'd13, 32'hcafef00d);
    st_(32'h0c, 32'h55667788, 5'd7);
    req(1'b0, 1'b1, 32'h0d, 32'h11223344, 5'd7, 5'd0, SPLIT ? 1 : 0, 0, 32'h0, !SPLIT);
    req(1'b1, 1'b0, 32'h0d, 32'h0, 5'd2, 5'd14, SPLIT ? 2 : 0, SPLIT ? 2 : 0, 32'h11223344, !SPLIT);
    ld(32'h0c, 5'd2, 5'd15, SPLIT ? 32'h22334488 : 32'h55667788);
    ld(32'h10, 5'd2, 5'd16, SPLIT ? 32'hdeadff11 : 32'hdeadffef);
    req(1'b1, 1'b0, 32'h0f, 32'h0, 5'd1, 5'd17, SPLIT ? 2 : 0, SPLIT ? 2 : 0, 32'h00001122, !SPLIT);
    st_(32'hffc, 32'ha1b2c3d4, 5'd7);
    req(1'b1, 1'b0, 32'hffe, 32'h0, 5'd2, 5'd18, SPLIT ? 2 : 0, SPLIT ? 2 : 0, 32'hf00da1b2, !SPLIT);
    ld(32'hffe, 5'd1, 5'd19, 32'hffffa1b2);
    mem_read_en = 1'b1; mem_addr = SPLIT ? 32'h0d : 32'h0c; mem_spec = 5'd2; rd_ind = 5'd20;
    @(posedge clk); #1;
    check("busy_before_rst", {31'b0, stall}, 32'd1);
    rst_n = 1'b0; mem_read_en = 1'b0;
    @(posedge clk); #1;
    check("midop_rst_stall", {31'b0, stall}, 32'd0);
    check("midop_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    ld(32'h0c, 5'd2, 5'd21, SPLIT ? 32'h22334488 : 32'h55667788);
    repeat (4) @(posedge clk);
    #1;
    check("wb_queue_empty", wbq.size(), 32'd0);
    check("fault_queue_empty", fq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage responder for load/store requests from the execute stage. Owns the data SRAM: decodes width and sign from the op spec, applies byte write enables for stores, and sign/zero-extends load data. It issues a registered writeback and holds a stall to the pipeline while a multi-cycle access is in flight. Sits between execute and writeback.

## Interface
- DEPTH_WORDS, 1024, data SRAM depth in 32-bit words; power of two; localparam AW = $clog2(DEPTH_WORDS).

- clk  in  1  clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- mem_read_en  in  1  load request this cycle.
- mem_write_en  in  1  store request this cycle.
- mem_addr  in  32  byte address.
- mem_dat  in  32  store data, right-aligned.
- mem_spec  in  5  0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw; others illegal.
- rd_ind  in  5  load destination register.
- stall  out  1  high: execute must hold all request inputs stable.
- wb_valid  out  1  one-cycle load-result strobe.
- wb_rd_ind  out  5  destination of wb_dat.
- wb_dat  out  32  extended load data.
- misalign_fault  out  1  one-cycle fault pulse.

## Operation
- Word index = mem_addr[AW+1:2], modulo DEPTH_WORDS; the upper address bits are ignored. The byte offset is mem_addr[1:0].
- A request is accepted only in IDLE with exactly one of read_en/write_en high.
- A request is illegal if both enables are high or mem_spec > 7. An illegal request causes no SRAM write, no wb, and pulses misalign_fault.
- A request is misaligned if it is half-width at offset 3, or word-width at offset ≠ 0.
- FSM states: IDLE, LD_RESP, LD_HI, ST_HI.
- Aligned load: IDLE→LD_RESP. In LD_RESP, extract the lane at the offset, extend it, and register wb_*. Then →IDLE.
- Misaligned load: IDLE→LD_HI. The low word is read at word index W and captured. W+1 is read, wrapping to 0 at the top of the array. Merge the two words, then →LD_RESP→IDLE.
- Aligned store: written in IDLE with byte enables = width mask << offset. The FSM stays in IDLE.
- Misaligned store: write the low-part bytes to W in IDLE, →ST_HI. Write the remaining bytes to W+1 (wrapped), then →IDLE.
- Extension: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word through.
- Reset values: state IDLE, stall 0, wb_valid 0, wb_rd_ind 0, wb_dat 0, misalign_fault 0. SRAM contents are not reset.
- Reset mid-operation returns to IDLE. Any pending high half of a store is dropped, and any partial load is discarded.

## Timing
- The SRAM has a synchronous read with 1-cycle latency. The read address is driven combinationally from the request in IDLE.
- Aligned load accepted at edge N: wb_valid is high for the cycle after edge N+1. stall is high in LD_RESP (1 cycle).
- Misaligned load: wb_valid follows edge N+2. stall is high for 2 cycles.
- Aligned store: written at edge N; stall is 0.
- Misaligned store: halves written at N and N+1; stall is high for 1 cycle (ST_HI).
- stall is combinational from the state: high in any non-IDLE state.
- Requests presented while stall is high are the held copy of the current request and are not re-accepted.
- Back-to-back aligned stores have a throughput of 1 per cycle.

## Configuration
- MEM_MISALIGN_SPLIT_EN defined: misaligned accesses split into two word accesses as above, and misaligned_fault fires only for illegal requests.
- MEM_MISALIGN_SPLIT_EN undefined: states LD_HI and ST_HI are absent. A misaligned request causes no SRAM write and no wb, pulses misalign_fault one cycle after acceptance, and does not stall.

## Structure
- Shared package mem_pkg contains:
  - mem_spec_e enum (the 8 codes);
  - mem_state_e;
  - a width-mask function;
  - localparams for the SPEC codes.
- Sub-module dmem_sram:
  - single port;
  - 32-bit with 4 byte write enables;
  - synchronous read;
  - parameter DEPTH_WORDS.
- Width decode, lane extraction/merge, and the FSM live in mem_access.

## Test plan
- sw 0xDEADBEEF @0x10, then lb @0x13 → wb_dat 0xFFFFFFDE 2 cycles after the load request; lbu @0x13 → 0x000000DE.
- sh 0x8001 @0x22, then lh @0x22 → 0xFFFF8001; lhu → 0x00008001; bytes 0x20–0x21 unchanged.
- With the macro: sw 0x11223344 @0x0D, then lw @0x0D → 0x11223344. stall is high for 1 cycle on the store and 2 on the load; word 3 bytes [3:1] and word 4 byte 0 are modified.
- Without the macro: the same lw @0x0D → misalign_fault pulse, wb_valid stays 0, SRAM unchanged.
- Wrap: with DEPTH_WORDS=1024, misaligned lw @0xFFE (top word) reads bytes 0xFFE–0xFFF then word 0; addr 0x1000 aliases to word 0.
- Reset during LD_HI, or mem_read_en and mem_write_en both high → IDLE / fault, no wb_valid, no SRAM write.
